qupls_alu_wb_buffer: RTL

Completion-side counterpart of the ALU reservation station. It accepts finished ALU results tagged with ROB index and destination registers, queues them in a small FIFO, and drains them to a shared register-file write port under an arbiter ack. On every drain it pulses ROB completion. It also provides the backpressure signal that feeds the station's `available` input.

---
 rtl/qupls_alu_wb_buffer_pkg.sv | 21 ++
 rtl/qupls_alu_wb_buffer_fifo.sv | 38 +++
 rtl/qupls_alu_wb_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/qupls_alu_wb_buffer_pkg.sv
// Shared types for the ALU writeback buffer: ROB/register index types and the queued result entry.
package QuplsPkg;
  localparam int WB_DEPTH = 4;
  localparam int EXC_W    = 8;

  typedef logic [4:0]  rob_ndx_t;
  typedef logic [8:0]  pregno_t;
  typedef logic [5:0]  aregno_t;
  typedef logic [63:0] value_t;
  typedef logic [2:0]  checkpt_ndx_t;

  typedef struct packed {
    rob_ndx_t           id;
    pregno_t            nRt;
    aregno_t            aRt;
    logic               aRtz;
    value_t             res;
    logic [EXC_W-1:0]   exc;
    checkpt_ndx_t       cp;
  } wb_entry_t;
endpackage

// File: rtl/qupls_alu_wb_buffer_fifo.sv
// Generic circular buffer of writeback entries with push/pop/flush and occupancy count.
module qupls_wb_fifo
  import QuplsPkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       dout,
  output logic [PTRW:0]   count
);
  wb_entry_t         mem [DEPTH];
  logic [PTRW-1:0]   head, tail;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTRW'(1);
      if (pop)  head <= head + PTRW'(1);
      count <= count + (PTRW+1)'(push) - (PTRW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[tail] <= din;
  end

  assign dout = mem[head];
endmodule

// File: rtl/qupls_alu_wb_buffer.sv
// ALU completion queue draining to a shared register-file write port and pulsing ROB completion.
// Optional same-cycle bypass of an empty queue: define QUPLS_WB_BYPASS_EN.
module qupls_alu_wb_buffer
  import QuplsPkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alu_done,
  input  rob_ndx_t           alu_id,
  input  pregno_t            alu_nRt,
  input  aregno_t            alu_aRt,
  input  logic               alu_aRtz,
  input  value_t             alu_res,
  input  logic [EXC_W-1:0]   alu_exc,
  input  checkpt_ndx_t       alu_cp,
  output logic               avail,
  output logic               wr_v,
  input  logic               wr_ack,
  output pregno_t            wr_nRt,
  output aregno_t            wr_aRt,
  output value_t             wr_res,
  output checkpt_ndx_t       wr_cp,
  output logic               rob_done,
  output rob_ndx_t           rob_id,
  output logic [EXC_W-1:0]   rob_exc,
  output logic               ovf
);
  wb_entry_t       in_e, head_e, out_e, done_e;
  logic [PTRW:0]   count;
  logic            hv, full, fifo_pop, byp, byp_pop, pop_any, push;

  assign in_e = '{id: alu_id, nRt: alu_nRt, aRt: alu_aRt, aRtz: alu_aRtz,
                  res: alu_res, exc: alu_exc, cp: alu_cp};

  assign hv       = (count != '0);
  assign full     = (count == (PTRW+1)'(DEPTH));
  assign avail    = ~full;
  // r0 destinations never need the write port, so they drain unacked.
  assign fifo_pop = hv & (head_e.aRtz | wr_ack);

`ifdef QUPLS_WB_BYPASS_EN
  assign byp     = ~hv & alu_done;
  assign byp_pop = byp & (alu_aRtz | wr_ack);
`else
  assign byp     = 1'b0;
  assign byp_pop = 1'b0;
`endif

  assign pop_any = fifo_pop | byp_pop;
  assign push    = alu_done & (~full | fifo_pop) & ~byp_pop;
  assign out_e   = byp ? in_e : head_e;
  assign done_e  = fifo_pop ? head_e : in_e;

  assign wr_v   = (hv | byp) & ~out_e.aRtz;
  assign wr_nRt = out_e.nRt;
  assign wr_aRt = out_e.aRt;
  assign wr_res = out_e.res;
  assign wr_cp  = out_e.cp;

  qupls_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (fifo_pop),
    .din   (in_e),
    .dout  (head_e),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_done <= 1'b0;
      rob_id   <= '0;
      rob_exc  <= '0;
    end else if (flush) begin
      rob_done <= 1'b0;
    end else begin
      rob_done <= pop_any;
      if (pop_any) begin
        rob_id  <= done_e.id;
        rob_exc <= done_e.exc;
      end
    end
  end

  // A result arriving while full with nothing leaving is lost; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (alu_done && full && !fifo_pop) ovf <= 1'b1;
  end
endmodule
